scan_select_sequencer: RTL

- Sequential front end that drives the select and enable inputs of the 2-to-4 line decoder with enable.
- Cycles a 2-bit index through the set bits of a 4-bit mask.
- Each index is held asserted (En=1) for a programmable dwell period, followed by a blanking gap (En=0) before the index advances.
- Typical use: multiplexed display digit scan and time-sliced bank select, where the decoder outputs must never overlap.

---
 rtl/scan_select_sequencer_pkg.sv | 18 +
 rtl/scan_select_sequencer_if.sv | 29 ++
 rtl/scan_select_sequencer_mask_next_index.sv | 33 +++
 rtl/scan_select_sequencer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/scan_select_sequencer_pkg.sv
// Shared definitions for the scan select sequencer: FSM state encodings and
// default parameter values used by the top level and the bus interface.
package scan_select_sequencer_pkg;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_BLANK = 2'd2
    } state_e;

    // Default width of the dwell divisor and dwell counter.
    localparam int PRESCALE_W_DEF  = 16;

    // Default number of all-low blanking cycles between indices (legal 1..15).
    localparam int DEAD_CYCLES_DEF = 2;

endpackage : scan_select_sequencer_pkg

// File: rtl/scan_select_sequencer_if.sv
// Bus between the scan sequencer and its controller/decoder side.
// Handshake semantics: there is no valid/ready pair on this bus. run, divisor
// and mask are levels sampled by the sequencer on every rising clk edge; sel1,
// sel0, En and frame_tick are registered levels (frame_tick is a one-cycle
// pulse). dbg_state mirrors the sequencer FSM state for observation.
interface scan_select_sequencer_if #(
    parameter int PRESCALE_W = scan_select_sequencer_pkg::PRESCALE_W_DEF
);
    logic                                    run;
    logic [PRESCALE_W-1:0]                   divisor;
    logic [3:0]                              mask;
    logic                                    sel1;
    logic                                    sel0;
    logic                                    En;
    logic                                    frame_tick;
    scan_select_sequencer_pkg::state_e       dbg_state;

    // Controller side: drives the scan configuration, observes the outputs.
    modport master (
        output run, divisor, mask,
        input  sel1, sel0, En, frame_tick, dbg_state
    );

    // Sequencer side.
    modport slave (
        input  run, divisor, mask,
        output sel1, sel0, En, frame_tick, dbg_state
    );
endinterface : scan_select_sequencer_if

// File: rtl/scan_select_sequencer_mask_next_index.sv
// Combinational search for the next enabled index: the first set mask bit
// strictly after cur_idx, scanning circularly (cur_idx+1 ... cur_idx+4).
// With cur_idx forced to 3 the result is the lowest set bit of the mask.
module mask_next_index (
    input  logic [1:0] cur_idx,
    input  logic [3:0] mask,
    output logic [1:0] next_idx,
    output logic       wrap,
    output logic       none
);
    logic [1:0] cand;
    logic       found;

    // Circular first-set-bit search; the fourth candidate is cur_idx itself,
    // which lets a single-bit mask select the same index again.
    always_comb begin
        next_idx = cur_idx;
        found    = 1'b0;
        cand     = cur_idx;
        for (int k = 1; k <= 4; k++) begin
            cand = cur_idx + 2'(k);
            if (!found && mask[cand]) begin
                next_idx = cand;
                found    = 1'b1;
            end
        end
    end

    // A result at or below the start point means the scan went round.
    assign wrap = (next_idx <= cur_idx);
    assign none = (mask == 4'b0000);

endmodule : mask_next_index

// File: rtl/scan_select_sequencer.sv
// Scan select sequencer: walks a 2-bit decoder select through the set bits of
// a mask, holding En high for a programmable dwell and low for a fixed
// blanking gap around every select change so decoder outputs never overlap.
module scan_select_sequencer
    import scan_select_sequencer_pkg::*;
#(
    parameter int PRESCALE_W  = PRESCALE_W_DEF,
    // Blanking cycles between indices; must be in 1..15.
    parameter int DEAD_CYCLES = DEAD_CYCLES_DEF
) (
    input  logic                          clk,
    input  logic                          rstN,
    scan_select_sequencer_if.slave        bus
);
    localparam logic [3:0] BLANK_LAST = 4'(DEAD_CYCLES - 1);

    state_e                state_q, state_d;
    logic [1:0]            sel_q, sel_d;
    logic                  en_q, en_d;
    logic                  tick_q, tick_d;
    logic [PRESCALE_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [3:0]            blank_cnt_q, blank_cnt_d;

    logic [1:0]            search_from;
    logic [1:0]            next_idx;
    logic                  next_wrap;
    logic                  mask_none;

    // In IDLE the search starts from 3 so it lands on the lowest set bit;
    // otherwise it continues after the index currently held.
    assign search_from = (state_q == ST_IDLE) ? 2'd3 : sel_q;

    mask_next_index u_next (
        .cur_idx  (search_from),
        .mask     (bus.mask),
        .next_idx (next_idx),
        .wrap     (next_wrap),
        .none     (mask_none)
    );

    // Next-state and next-output computation for the scan FSM.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        en_d        = en_q;
        tick_d      = 1'b0;
        dwell_cnt_d = dwell_cnt_q;
        blank_cnt_d = blank_cnt_q;

        if (!bus.run) begin
            // Stopping wins over everything; select is held, decoder off.
            state_d     = ST_IDLE;
            en_d        = 1'b0;
            dwell_cnt_d = '0;
            blank_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    en_d = 1'b0;
                    if (!mask_none) begin
                        state_d     = ST_DWELL;
                        sel_d       = next_idx;
                        en_d        = 1'b1;
                        tick_d      = 1'b1;
                        dwell_cnt_d = '0;
                    end
                end
                ST_DWELL: begin
                    // Terminal count and a cleared own-mask-bit share one exit.
                    if ((dwell_cnt_q >= bus.divisor) || !bus.mask[sel_q]) begin
                        state_d     = ST_BLANK;
                        en_d        = 1'b0;
                        dwell_cnt_d = '0;
                        blank_cnt_d = '0;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + 1'b1;
                    end
                end
                ST_BLANK: begin
                    en_d = 1'b0;
                    if (blank_cnt_q == BLANK_LAST) begin
                        blank_cnt_d = '0;
                        if (mask_none) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d     = ST_DWELL;
                            sel_d       = next_idx;
                            en_d        = 1'b1;
                            tick_d      = next_wrap;
                            dwell_cnt_d = '0;
                        end
                    end else begin
                        blank_cnt_d = blank_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    en_d        = 1'b0;
                    dwell_cnt_d = '0;
                    blank_cnt_d = '0;
                end
            endcase
        end
    end

    // State and output registers; reset drops En asynchronously.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q     <= ST_IDLE;
            sel_q       <= 2'd0;
            en_q        <= 1'b0;
            tick_q      <= 1'b0;
            dwell_cnt_q <= '0;
            blank_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            en_q        <= en_d;
            tick_q      <= tick_d;
            dwell_cnt_q <= dwell_cnt_d;
            blank_cnt_q <= blank_cnt_d;
        end
    end

    assign bus.sel1       = sel_q[1];
    assign bus.sel0       = sel_q[0];
    assign bus.En         = en_q;
    assign bus.frame_tick = tick_q;
    assign bus.dbg_state  = state_q;

endmodule : scan_select_sequencer
